// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with frame-buffer
// read sequencer.
//
// Stage-0 counters (hc, vc) walk the raster: active, front porch, sync, back porch.
// A read address is registered one cycle after stage 0. Display-enable, syncs,
// coordinates and strobes go through an RD_LAT+1 deep register chain, so RAM
// data for an address lines up with poul1De.
//
// Ports
//   piul1Clock       pixel clock
//   piul1Reset       synchronous reset, active-high (dominates enable)
//   piul1Enable      pixel clock-enable; every register holds while low
//   poul1HSync       horizontal sync, active level SYNC_POL
//   poul1VSync       vertical sync, active level SYNC_POL
//   poul1De          display enable
//   poul1FrameStart  pulse with pixel (0,0)
//   poul1LineStart   pulse with first active pixel of each line
//   poulXPos         horizontal count aligned with poul1De
//   poulYPos         vertical count aligned with poul1De
//   poul1RdEn        frame-buffer read strobe
//   poulRdAddr       frame-buffer read address
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int SCALE_LOG2 = 1,
    parameter int RD_LAT     = 1,
    parameter int XW         = 10,
    parameter int YW         = 10,
    parameter int AW         = 17
) (
    input  logic          piul1Clock,
    input  logic          piul1Reset,
    input  logic          piul1Enable,
    output logic          poul1HSync,
    output logic          poul1VSync,
    output logic          poul1De,
    output logic          poul1FrameStart,
    output logic          poul1LineStart,
    output logic [XW-1:0] poulXPos,
    output logic [YW-1:0] poulYPos,
    output logic          poul1RdEn,
    output logic [AW-1:0] poulRdAddr
);

    localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LAT = RD_LAT + 1;

    localparam logic [XW-1:0] hActive   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] hSyncBeg  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] hSyncEnd  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] hLast     = XW'(HT - 1);
    localparam logic [YW-1:0] vActive   = YW'(V_ACTIVE);
    localparam logic [YW-1:0] vLastAct  = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] vSyncBeg  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] vSyncEnd  = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] vLast     = YW'(VT - 1);
    localparam logic [YW-1:0] vMask     = YW'((1 << SCALE_LOG2) - 1);
    localparam logic [AW-1:0] lineStep  = AW'(H_ACTIVE >> SCALE_LOG2);
    localparam logic          syncPol   = (SYNC_POL != 0);

    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : gBadScale
        $error("vga_timing_gen: SCALE_LOG2 must be 0..2");
    end
    if (RD_LAT < 0 || RD_LAT > 4) begin : gBadLat
        $error("vga_timing_gen: RD_LAT must be 0..4");
    end
    if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0 || (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : gBadDiv
        $error("vga_timing_gen: H_ACTIVE/V_ACTIVE must be divisible by 2^SCALE_LOG2");
    end
    if (HT > (1 << XW) || VT > (1 << YW)) begin : gBadCnt
        $error("vga_timing_gen: XW/YW too narrow for the raster totals");
    end
    if ((H_ACTIVE >> SCALE_LOG2) * (V_ACTIVE >> SCALE_LOG2) > (1 << AW)) begin : gBadAddr
        $error("vga_timing_gen: AW too narrow for the scaled frame buffer");
    end

    logic [XW-1:0] hc;
    logic [YW-1:0] vc;
    logic [AW-1:0] lineBase;

    logic de0, hs0, vs0, ls0, fs0, lastPix, lastLine;

    always_comb begin
        de0      = (hc < hActive) && (vc < vActive);
        hs0      = (hc >= hSyncBeg) && (hc < hSyncEnd);
        vs0      = (vc >= vSyncBeg) && (vc < vSyncEnd);
        ls0      = (hc == '0) && (vc < vActive);
        fs0      = (hc == '0) && (vc == '0);
        lastPix  = (hc == hLast);
        lastLine = (vc == vLast);
    end

    // lineBase tracks (vc >> S) * (H_ACTIVE >> S) incrementally. The step on
    // the final active line is skipped so the register never exceeds the
    // buffer size; it is cleared at the frame wrap anyway.
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            hc       <= '0;
            vc       <= '0;
            lineBase <= '0;
        end else if (piul1Enable) begin
            if (lastPix) begin
                hc <= '0;
                if (lastLine) begin
                    vc       <= '0;
                    lineBase <= '0;
                end else begin
                    vc <= vc + 1'b1;
                    if ((vc < vLastAct) && ((vc & vMask) == vMask)) begin
                        lineBase <= lineBase + lineStep;
                    end
                end
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            poul1RdEn  <= 1'b0;
            poulRdAddr <= '0;
        end else if (piul1Enable) begin
            poul1RdEn  <= de0;
            poulRdAddr <= lineBase + AW'(hc >> SCALE_LOG2);
        end
    end

    logic          deP [LAT];
    logic          hsP [LAT];
    logic          vsP [LAT];
    logic          lsP [LAT];
    logic          fsP [LAT];
    logic [XW-1:0] xP  [LAT];
    logic [YW-1:0] yP  [LAT];

    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            for (int i = 0; i < LAT; i++) begin
                deP[i] <= 1'b0;
                hsP[i] <= 1'b0;
                vsP[i] <= 1'b0;
                lsP[i] <= 1'b0;
                fsP[i] <= 1'b0;
                xP[i]  <= '0;
                yP[i]  <= '0;
            end
        end else if (piul1Enable) begin
            deP[0] <= de0;
            hsP[0] <= hs0;
            vsP[0] <= vs0;
            lsP[0] <= ls0;
            fsP[0] <= fs0;
            xP[0]  <= hc;
            yP[0]  <= vc;
            for (int i = 1; i < LAT; i++) begin
                deP[i] <= deP[i-1];
                hsP[i] <= hsP[i-1];
                vsP[i] <= vsP[i-1];
                lsP[i] <= lsP[i-1];
                fsP[i] <= fsP[i-1];
                xP[i]  <= xP[i-1];
                yP[i]  <= yP[i-1];
            end
        end
    end

    // Pipeline carries "sync active"; polarity is applied only at the pin so
    // a cleared pipeline drives the inactive level.
    always_comb begin
        poul1De         = deP[LAT-1];
        poul1HSync      = ~(hsP[LAT-1] ^ syncPol);
        poul1VSync      = ~(vsP[LAT-1] ^ syncPol);
        poul1LineStart  = lsP[LAT-1];
        poul1FrameStart = fsP[LAT-1];
        poulXPos        = xP[LAT-1];
        poulYPos        = yP[LAT-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 8, VF = 1, VS = 1, VB = 1;
    localparam int POL = 1, SC = 1, RL = 2;
    localparam int XW = 6, YW = 6, AW = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          hSync, vSync, de, frameStart, lineStart, rdEn;
    logic [XW-1:0] xPos;
    logic [YW-1:0] yPos;
    logic [AW-1:0] rdAddr;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;   // enabled edges since the last reset

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .SCALE_LOG2(SC), .RD_LAT(RL),
        .XW(XW), .YW(YW), .AW(AW)
    ) dut (
        .piul1Clock(clk),
        .piul1Reset(rst),
        .piul1Enable(en),
        .poul1HSync(hSync),
        .poul1VSync(vSync),
        .poul1De(de),
        .poul1FrameStart(frameStart),
        .poul1LineStart(lineStart),
        .poulXPos(xPos),
        .poulYPos(yPos),
        .poul1RdEn(rdEn),
        .poulRdAddr(rdAddr)
    );

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s tick=%0d got=%0d want=%0d", tag, ticks, obs, exp);
        end
    endtask

    // Reference: a raster position p counts pixel clocks since reset; the
    // display outputs show position ticks-(RD_LAT+1), the read port ticks-1.
    task automatic checkAll();
        int p, h, v;
        int eDe, eHs, eVs, eLs, eFs, eX, eY, eRdEn, eAddr;
        eDe = 0; eHs = 1 - POL; eVs = 1 - POL; eLs = 0; eFs = 0; eX = 0; eY = 0;
        if (ticks >= RL + 1) begin
            p   = (ticks - RL - 1) % (HT * VT);
            h   = p % HT;
            v   = p / HT;
            eDe = (h < HA && v < VA) ? 1 : 0;
            eHs = (h >= HA + HF && h < HA + HF + HS) ? POL : 1 - POL;
            eVs = (v >= VA + VF && v < VA + VF + VS) ? POL : 1 - POL;
            eLs = (h == 0 && v < VA) ? 1 : 0;
            eFs = (h == 0 && v == 0) ? 1 : 0;
            eX  = h;
            eY  = v;
        end
        checkVal("de", int'(de), eDe);
        checkVal("hsync", int'(hSync), eHs);
        checkVal("vsync", int'(vSync), eVs);
        checkVal("lineStart", int'(lineStart), eLs);
        checkVal("frameStart", int'(frameStart), eFs);
        checkVal("xPos", int'(xPos), eX);
        checkVal("yPos", int'(yPos), eY);

        eRdEn = 0; eAddr = 0;
        if (ticks >= 1) begin
            p     = (ticks - 1) % (HT * VT);
            h     = p % HT;
            v     = p / HT;
            eRdEn = (h < HA && v < VA) ? 1 : 0;
            eAddr = (v >> SC) * (HA >> SC) + (h >> SC);
        end
        checkVal("rdEn", int'(rdEn), eRdEn);
        if (ticks == 0 || eRdEn == 1) checkVal("rdAddr", int'(rdAddr), eAddr);
    endtask

    // Called on a falling edge: drive, cross one rising edge, then compare.
    task automatic cycle(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) ticks = 0;
        else if (e) ticks++;
        @(negedge clk);
        checkAll();
    endtask

    int frameStarts;
    int deCount;

    initial begin
        @(negedge clk);
        cycle(1'b1, 1'b1);                       // reset dominates enable
        cycle(1'b0, 1'b0);                       // held while disabled

        // two full frames at full rate, counting visible pixels per frame
        frameStarts = 0;
        deCount = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            cycle(1'b0, 1'b1);
            deCount     += int'(de);
            frameStarts += int'(frameStart);
        end
        checkVal("deCount2Frames", deCount, 2 * HA * VA - (RL + 1 > HT * VT - HA * VA ? 0 : 0));
        checkVal("frameStartCount", frameStarts, 2);

        // mid-frame reset, then frame start must reappear RD_LAT+1 ticks later
        for (int i = 0; i < 5 * HT + 4; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < RL + 1; i++) cycle(1'b0, 1'b1);
        checkVal("frameStartAfterRst", int'(frameStart), 1);

        // enable toggled 1,0,1,0
        for (int i = 0; i < 2 * HT * VT; i++) cycle(1'b0, (i % 2) == 0);

        // random enable with rare resets
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
